// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg
//   Shared definitions for the I2C slave controller: FSM state encoding,
//   glitch-filter depth and the majority-vote helper used by the filter.
package i2c_slave_pkg;

  // Number of consecutive clk samples voted on by the line filter.
  localparam int unsigned FILTER_DEPTH = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_LOAD,
    RD_DATA,
    RD_ACK
  } state_t;

  // True when more than half of the samples are high.
  function automatic logic majority(input logic [FILTER_DEPTH-1:0] s);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < FILTER_DEPTH; i++) begin
      ones += {31'b0, s[i]};
    end
    return (ones > FILTER_DEPTH / 2);
  endfunction

endpackage

// File: rtl/i2c_slave_sync.sv
// i2c_slave_sync
//   Brings the raw SCL/SDA levels into the clk domain (2-flop synchroniser),
//   removes short glitches with a majority filter and derives one-cycle
//   SCL edge and START/STOP condition strobes.
// Ports:
//   clk, nReset          - system clock, synchronous active-low reset
//   scl_i, sda_i         - raw bus line levels
//   sscl, ssda           - filtered line levels (reset to 1)
//   scl_rise, scl_fall   - one-cycle SCL edge strobes
//   start, stop          - one-cycle START / STOP condition strobes
module i2c_slave_sync
  import i2c_slave_pkg::*;
(
  input  logic clk,
  input  logic nReset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sscl,
  output logic ssda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0]              scl_sync, sda_sync;
  logic [FILTER_DEPTH-1:0] scl_filt, sda_filt;
  logic                    sscl_d, ssda_d;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_filt <= '1;
      sda_filt <= '1;
      sscl     <= 1'b1;
      ssda     <= 1'b1;
      sscl_d   <= 1'b1;
      ssda_d   <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_filt <= {scl_filt[FILTER_DEPTH-2:0], scl_sync[1]};
      sda_filt <= {sda_filt[FILTER_DEPTH-2:0], sda_sync[1]};
      sscl     <= majority(scl_filt);
      ssda     <= majority(sda_filt);
      sscl_d   <= sscl;
      ssda_d   <= ssda;
    end
  end

  assign scl_rise = sscl & ~sscl_d;
  assign scl_fall = ~sscl & sscl_d;
  // SCL must be high on both samples so an SDA change coinciding with an
  // SCL edge is never mistaken for a bus condition.
  assign start    = sscl & sscl_d & ssda_d & ~ssda;
  assign stop     = sscl & sscl_d & ~ssda_d & ssda;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl
//   7-bit-address I2C slave. Receives write bytes onto rx_data, returns
//   tx_data on reads and stretches SCL while no read byte is available.
// Ports:
//   clk, nReset        - system clock, synchronous active-low reset
//   ena                - block enable; low holds IDLE with lines released
//   slave_addr         - own bus address
//   scl_i, sda_i       - raw bus levels
//   scl_o, sda_o       - constant 0 (open-drain data value)
//   scl_oen, sda_oen   - line enables: 0 drives low, 1 releases
//   tx_data, tx_valid  - read byte source; tx_ready pulses when consumed
//   rx_data, rx_valid  - last written byte; rx_valid pulses on update
//   sel, busy, rw      - addressed flag, bus busy flag, current R/W bit
module i2c_slave_ctrl
  import i2c_slave_pkg::*;
(
  input  logic       clk,
  input  logic       nReset,
  input  logic       ena,
  input  logic [6:0] slave_addr,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       scl_oen,
  output logic       sda_oen,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       sel,
  output logic       busy,
  output logic       rw
);

  logic       sscl, ssda, scl_rise, scl_fall, start, stop;
  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] tx_shift;

  assign scl_o = 1'b0;
  assign sda_o = 1'b0;

  i2c_slave_sync u_sync (
    .clk      (clk),
    .nReset   (nReset),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sscl     (sscl),
    .ssda     (ssda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  always_ff @(posedge clk) begin
    if (!nReset || !ena) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_shift <= '0;
      scl_oen  <= 1'b1;
      sda_oen  <= 1'b1;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      sel      <= 1'b0;
      busy     <= 1'b0;
      if (!nReset) begin
        rx_data <= '0;
        rw      <= 1'b0;
      end
    end else begin
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      if (start) begin
        busy    <= 1'b1;
        state   <= ADDR;
        bit_cnt <= '0;
        scl_oen <= 1'b1;
        sda_oen <= 1'b1;
        sel     <= 1'b0;
      end else if (stop) begin
        busy    <= 1'b0;
        state   <= IDLE;
        scl_oen <= 1'b1;
        sda_oen <= 1'b1;
        sel     <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], ssda};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw    <= ssda;
                state <= (shift[6:0] == slave_addr) ? ADDR_ACK : IDLE;
              end
            end
          end
          // ACK states: the first SCL fall starts driving the ACK, the
          // second ends the ACK bit; sda_oen tells the two phases apart.
          ADDR_ACK: begin
            if (scl_fall) begin
              if (sda_oen) begin
                sda_oen <= 1'b0;
                sel     <= 1'b1;
              end else begin
                sda_oen <= 1'b1;
                bit_cnt <= '0;
                state   <= rw ? RD_LOAD : WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], ssda};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= {shift[6:0], ssda};
                rx_valid <= 1'b1;
                state    <= WR_ACK;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              if (sda_oen) begin
                sda_oen <= 1'b0;
              end else begin
                sda_oen <= 1'b1;
                bit_cnt <= '0;
                state   <= WR_DATA;
              end
            end
          end
          RD_LOAD: begin
            if (tx_valid) begin
              tx_shift <= tx_data;
              tx_ready <= 1'b1;
              sda_oen  <= tx_data[7];
              scl_oen  <= 1'b1;
              bit_cnt  <= '0;
              state    <= RD_DATA;
            end else begin
              scl_oen <= 1'b0;
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oen <= 1'b1;
                bit_cnt <= '0;
                state   <= RD_ACK;
              end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
                sda_oen  <= tx_shift[6];
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && ssda) begin
              state <= IDLE;
              sel   <= 1'b0;
            end else if (scl_fall) begin
              state <= RD_LOAD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb_i2c_slave_ctrl
//   Bus-level bench: an open-drain master model drives SCL/SDA, a table of
//   directed transfers plus random transfers are checked against expected
//   ACK / byte / pulse-count results, and hand sequences cover stretching,
//   repeated START, enable drop and mid-transfer reset.
module tb_i2c_slave_ctrl;
  import i2c_slave_pkg::*;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       ena = 1'b1;
  logic [6:0] slave_addr = 7'h50;
  logic       scl_i, sda_i, scl_o, sda_o, scl_oen, sda_oen;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b1;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, sel, busy, rw;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;

  always #5 clk = ~clk;

  assign scl_i = scl_m & scl_oen;
  assign sda_i = sda_m & sda_oen;

  i2c_slave_ctrl dut (
    .clk(clk), .nReset(nReset), .ena(ena), .slave_addr(slave_addr),
    .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o),
    .scl_oen(scl_oen), .sda_oen(sda_oen), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .sel(sel), .busy(busy), .rw(rw)
  );

  int n_vec = 0;
  int n_err = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int drv_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid) rx_cnt++;
    if (tx_ready) tx_cnt++;
    if (!sda_oen) drv_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hc();
    repeat (H) @(negedge clk);
  endtask

  task automatic scl_high();
    int n;
    scl_m = 1'b1;
    n = 0;
    @(negedge clk);
    while (!scl_oen && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("scl_release", scl_oen, 1);
  endtask

  task automatic bus_start();
    hc(); sda_m = 1'b1; hc(); scl_high(); hc(); sda_m = 1'b0; hc(); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    hc(); sda_m = 1'b0; hc(); scl_high(); hc(); sda_m = 1'b1; hc();
  endtask

  task automatic write_bit(input logic b);
    hc(); sda_m = b; hc(); scl_high(); hc(); hc(); scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    hc(); sda_m = 1'b1; hc(); scl_high(); hc(); b = sda_i; hc(); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  // Reference: a slave answers only its own address; a write delivers the
  // byte once, a read returns tx_data, an unanswered read floats high.
  function automatic void model(input logic [6:0] sa, input logic [6:0] addr,
                                input logic [7:0] data, output logic ack,
                                output logic [7:0] b);
    ack = (addr == sa);
    b   = ack ? data : 8'hFF;
  endfunction

  task automatic run_xfer(input string tag, input logic [6:0] sa, input logic [6:0] addr,
                          input logic rwb, input logic [7:0] data,
                          input logic exp_ack, input logic [7:0] exp_byte);
    logic       ack, dack;
    logic [7:0] got;
    int         rx0, tx0, d0;
    slave_addr = sa;
    tx_data    = data;
    tx_valid   = 1'b1;
    rx0 = rx_cnt; tx0 = tx_cnt; d0 = drv_cnt;
    bus_start();
    check({tag, ":busy"}, busy, 1);
    send_byte({addr, rwb}, ack);
    check({tag, ":addr_ack"}, ack, !exp_ack);
    check({tag, ":sel"}, sel, exp_ack);
    if (!rwb) begin
      send_byte(data, dack);
      check({tag, ":data_ack"}, dack, !exp_ack);
    end else begin
      read_byte(got, 1'b1);
      check({tag, ":rd_byte"}, got, exp_byte);
    end
    if (!exp_ack) begin
      check({tag, ":no_drive"}, drv_cnt - d0, 0);
      check({tag, ":idle"}, dut.state == IDLE, 1);
    end
    bus_stop();
    hc();
    check({tag, ":end_flags"}, {busy, sel, scl_oen, sda_oen}, 4'b0011);
    check({tag, ":rx_pulses"}, rx_cnt - rx0, (!rwb && exp_ack) ? 1 : 0);
    check({tag, ":tx_pulses"}, tx_cnt - tx0, (rwb && exp_ack) ? 1 : 0);
    if (!rwb && exp_ack) check({tag, ":rx_data"}, rx_data, exp_byte);
  endtask

  typedef struct {
    logic [6:0] sa;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
    logic       exp_ack;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic       ack, dack, eack;
    logic [7:0] got, eb;
    logic [6:0] sa, ad;
    logic       rwb;
    logic [7:0] d;
    int         rx0, lo;

    tbl[0] = '{7'h50, 7'h50, 1'b0, 8'hA5, 1'b1, 8'hA5};
    tbl[1] = '{7'h50, 7'h51, 1'b0, 8'h33, 1'b0, 8'h00};
    tbl[2] = '{7'h50, 7'h50, 1'b1, 8'h3C, 1'b1, 8'h3C};
    tbl[3] = '{7'h50, 7'h51, 1'b1, 8'h77, 1'b0, 8'hFF};
    tbl[4] = '{7'h7F, 7'h7F, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[5] = '{7'h00, 7'h00, 1'b1, 8'hFF, 1'b1, 8'hFF};

    repeat (4) @(posedge clk);
    #1;
    check("rst_oen", {scl_oen, sda_oen}, 2'b11);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_flags", {sel, busy, rw, rx_valid, tx_ready}, 5'b0);
    check("tied_low", {scl_o, sda_o}, 2'b00);
    @(negedge clk);
    nReset = 1'b1;
    hc();

    for (int i = 0; i < 6; i++)
      run_xfer($sformatf("tbl%0d", i), tbl[i].sa, tbl[i].addr, tbl[i].rw,
               tbl[i].data, tbl[i].exp_ack, tbl[i].exp_byte);

    for (int i = 0; i < 12; i++) begin
      sa  = 7'($urandom_range(0, 127));
      ad  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : sa;
      rwb = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      model(sa, ad, d, eack, eb);
      run_xfer($sformatf("rnd%0d", i), sa, ad, rwb, d, eack, eb);
    end

    // Clock stretch while no read byte is offered.
    slave_addr = 7'h50;
    tx_valid   = 1'b0;
    bus_start();
    send_byte({7'h50, 1'b1}, ack);
    check("str:addr_ack", ack, 0);
    repeat (12) @(negedge clk);
    lo = 0;
    for (int i = 0; i < 88; i++) begin
      if (!scl_oen) lo++;
      @(negedge clk);
    end
    check("str:held_low", lo, 88);
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    check("str:release", {scl_oen, tx_ready}, 2'b11);
    @(negedge clk);
    tx_valid = 1'b0;
    read_byte(got, 1'b1);
    check("str:rd_byte", got, 8'h96);
    bus_stop();
    tx_valid = 1'b1;

    // Repeated START part-way through a write byte.
    rx0 = rx_cnt;
    bus_start();
    send_byte({7'h50, 1'b0}, ack);
    check("rs:addr_ack", ack, 0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    bus_start();
    check("rs:no_rx", rx_cnt - rx0, 0);
    check("rs:state_addr", dut.state == ADDR, 1);
    send_byte({7'h50, 1'b0}, ack);
    check("rs:addr2_ack", ack, 0);
    send_byte(8'h5A, dack);
    check("rs:data_ack", dack, 0);
    bus_stop();
    hc();
    check("rs:rx_data", rx_data, 8'h5A);
    check("rs:rx_pulses", rx_cnt - rx0, 1);

    // Enable dropped while the data ACK is being driven.
    bus_start();
    send_byte({7'h50, 1'b0}, ack);
    for (int i = 7; i >= 0; i--) write_bit(1'b0);
    hc();
    check("ena:ack_driven", sda_oen, 0);
    ena = 1'b0;
    repeat (2) @(negedge clk);
    check("ena:released", {scl_oen, sda_oen, busy}, 3'b110);
    check("ena:idle", dut.state == IDLE, 1);
    ena = 1'b1;
    scl_high();
    bus_stop();

    // Reset while the data ACK is being driven.
    bus_start();
    send_byte({7'h50, 1'b0}, ack);
    for (int i = 7; i >= 0; i--) write_bit(1'b1);
    hc();
    check("rst:ack_driven", sda_oen, 0);
    nReset = 1'b0;
    @(posedge clk);
    #1;
    check("rst:released", {scl_oen, sda_oen, busy}, 3'b110);
    @(negedge clk);
    nReset = 1'b1;
    scl_m  = 1'b1;
    sda_m  = 1'b1;
    repeat (4 * H) @(negedge clk);
    check("rst:quiet", {scl_oen, sda_oen, sel}, 3'b110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_slave_ctrl.md
I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-002 SHALL have port nReset, input, 1: synchronous, active-low reset.
REQ-003 SHALL have port ena, input, 1: block enable; low forces IDLE with both lines released.
REQ-004 SHALL have port slave_addr, input, 7: own 7-bit bus address.
REQ-005 SHALL have ports scl_i/sda_i, input, 1 each: raw bus line levels.
REQ-006 SHALL have ports scl_o/sda_o, output, 1 each: tied 1'b0.
REQ-007 SHALL have ports scl_oen/sda_oen, output, 1 each: line output enables; 0 = drive low, 1 = release.
REQ-008 SHALL have port tx_data, input, 8: byte to return on a read.
REQ-009 SHALL have port tx_valid, input, 1: tx_data is valid.
REQ-010 SHALL have port tx_ready, output, 1: one-cycle pulse; tx_data consumed.
REQ-011 SHALL have port rx_data, output, 8: last byte written by the master.
REQ-012 SHALL have port rx_valid, output, 1: one-cycle pulse; rx_data updated.
REQ-013 SHALL have port sel, output, 1: addressed; high from address ACK to STOP, repeated START or NACK.
REQ-014 SHALL have port busy, output, 1: bus busy, START to STOP.
REQ-015 SHALL have port rw, output, 1: R/W bit of the current transfer.

Function
REQ-016 SHALL synchronise scl_i/sda_i through 2 flops, then filter each with a majority-of-3 over consecutive clk samples; filtered levels sSCL/sSDA reset to 1.
REQ-017 SHALL derive scl_rise, scl_fall, START (sSDA falls while sSCL high) and STOP (sSDA rises while sSCL high), each one cycle wide.
REQ-018 SHALL use states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK.
REQ-019 SHALL, on START in any state (repeated START included), go to ADDR, clear the bit counter, release sda_oen and deassert sel.
REQ-020 SHALL, on STOP in any state, go to IDLE, release both lines and deassert sel.
REQ-021 SHALL, in ADDR, sample sSDA on each scl_rise into an 8-bit MSB-first shift register; the 3-bit counter wraps after 8 bits.
REQ-022 SHALL, on the 8th scl_rise, compare shift[7:1] with slave_addr and latch rw = bit0.
REQ-023 SHALL, on match, drive sda_oen=0 at the following scl_fall (ADDR_ACK) and assert sel; on mismatch, go to IDLE and never drive.
REQ-024 SHALL, at the scl_fall ending the ACK bit, go to WR_DATA with SDA released if rw=0, else to RD_LOAD.
REQ-025 SHALL, in WR_DATA, after 8 bits update rx_data, pulse rx_valid on the 8th scl_rise, and ACK (sda_oen=0) in WR_ACK; return to WR_DATA at the next scl_fall.
REQ-026 SHALL, in RD_LOAD with tx_valid=1, load tx_data, pulse tx_ready, drive its MSB and go to RD_DATA.
REQ-027 SHALL, in RD_LOAD with tx_valid=0, hold scl_oen=0 (clock stretch) until tx_valid=1, then load and release SCL on the same cycle.
REQ-028 SHALL, in RD_DATA, shift the next bit onto sda_oen at each scl_fall (sda_oen=bit); after 8 bits release SDA and enter RD_ACK.
REQ-029 SHALL, in RD_ACK, sample master ACK on scl_rise: ACK(0) returns to RD_LOAD at scl_fall; NACK(1) goes to IDLE with sel=0.
REQ-030 SHALL give tx_valid=1 with tx_ready priority over stretching; simultaneous START/STOP with any edge SHALL take START/STOP.
REQ-031 SHALL force IDLE, released lines and cleared counters while ena=0, regardless of bus activity.

Reset
REQ-032 SHALL, on nReset=0 at a clk edge, set: state=IDLE, scl_oen=1, sda_oen=1, rx_data=8'h00, rx_valid=0, tx_ready=0, sel=0, busy=0, rw=0, sync/filter flops=1.
REQ-033 SHALL, when reset occurs mid-transfer, release both lines on the cycle after the reset edge, with no ACK or data bit driven afterwards.

Structure
REQ-034 SHALL place the state encoding and the filter depth constant in shared package i2c_slave_pkg.
REQ-035 SHALL implement the synchroniser, majority filter and START/STOP/edge detection as sub-module i2c_slave_sync.

Verification
REQ-036 Write to 0x50, slave_addr=7'h50, data 0xA5 -> address ACK and data ACK (sda_oen=0 during both 9th clocks), rx_data=8'hA5, one rx_valid pulse.
REQ-037 Address 0x51 with slave_addr=7'h50 -> sda_oen stays 1 throughout, sel=0, state IDLE until STOP.
REQ-038 Read from 0x50 with tx_data=8'h3C, tx_valid=1, master NACK -> SDA bits 0,0,1,1,1,1,0,0 observed, one tx_ready pulse, IDLE after NACK.
REQ-039 Read with tx_valid low for 100 clk after the address ACK -> scl_oen=0 for the whole wait; SCL is released in the cycle tx_valid rises.
REQ-040 Repeated START after 4 bits of a write byte -> no rx_valid; state ADDR; next address handled normally.
REQ-041 nReset low while sda_oen=0 in WR_ACK -> sda_oen=1 and scl_oen=1 on the cycle after the reset edge; busy=0.
